// File: rtl/pigro_alu.sv
`default_nettype none
// ============================================================================
// Module      : pigro_alu
// Description : 32-bit signed integer ALU for the PIGRO execution stage.
//               Executes ADD, SUB, AND, OR, XOR, NOT, LSH, RSH and ARSH.
//               The result and the overflow/error flags are registered and
//               update only on clock edges where enable is high.
// Optional    : define ALU_MUL_EN to add opcode 10 = MUL (signed 32x32,
//               low half of the product, overflow when the product does not
//               fit in WIDTH signed bits).
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset (overrides enable)
//               data_a   - operand A (signed)
//               data_b   - operand B (signed); low SHW bits give shift amount
//               opcode   - 5-bit operation code
//               enable   - execute the operation on this edge
//               data_out - registered result
//               overflow - registered signed-overflow flag
//               error    - registered illegal-operation flag
// Revision    : 1.0 - initial release
// ============================================================================
module pigro_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [4:0]       opcode,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             overflow,
  output logic             error
);

  localparam logic [4:0] c_OP_NOP  = 5'd0;
  localparam logic [4:0] c_OP_ADD  = 5'd1;
  localparam logic [4:0] c_OP_SUB  = 5'd2;
  localparam logic [4:0] c_OP_AND  = 5'd3;
  localparam logic [4:0] c_OP_OR   = 5'd4;
  localparam logic [4:0] c_OP_XOR  = 5'd5;
  localparam logic [4:0] c_OP_NOT  = 5'd6;
  localparam logic [4:0] c_OP_LSH  = 5'd7;
  localparam logic [4:0] c_OP_RSH  = 5'd8;
  localparam logic [4:0] c_OP_ARSH = 5'd9;
`ifdef ALU_MUL_EN
  localparam logic [4:0] c_OP_MUL  = 5'd10;
`endif

  logic [WIDTH-1:0] r_data;
  logic             r_ovf;
  logic             r_err;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic             w_shbad;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_err;
  logic             w_load;   // result register takes w_res this edge

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_prod_hi;

  assign w_prod    = $signed(data_a) * $signed(data_b);
  // Product fits in WIDTH signed bits only if the top WIDTH+1 bits are
  // a pure sign extension (all zeros or all ones).
  assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH-1];
`endif

  assign w_sum   = data_a + data_b;
  assign w_diff  = data_a - data_b;
  assign w_shamt = data_b[SHW-1:0];
  // Any set bit above the shift field means a negative or oversized amount.
  assign w_shbad = |data_b[WIDTH-1:SHW];

  always_comb begin
    w_res  = '0;
    w_ovf  = 1'b0;
    w_err  = 1'b0;
    w_load = 1'b0;
    case (opcode)
      c_OP_NOP: begin
        // result holds, flags clear
      end
      c_OP_ADD: begin
        w_load = 1'b1;
        w_res  = w_sum;
        w_ovf  = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != data_a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_load = 1'b1;
        w_res  = w_diff;
        w_ovf  = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                 (w_diff[WIDTH-1] != data_a[WIDTH-1]);
      end
      c_OP_AND: begin
        w_load = 1'b1;
        w_res  = data_a & data_b;
      end
      c_OP_OR: begin
        w_load = 1'b1;
        w_res  = data_a | data_b;
      end
      c_OP_XOR: begin
        w_load = 1'b1;
        w_res  = data_a ^ data_b;
      end
      c_OP_NOT: begin
        w_load = 1'b1;
        w_res  = ~data_a;
      end
      c_OP_LSH: begin
        w_load = 1'b1;
        w_err  = w_shbad;
        w_res  = w_shbad ? '0 : (data_a << w_shamt);
      end
      c_OP_RSH: begin
        w_load = 1'b1;
        w_err  = w_shbad;
        w_res  = w_shbad ? '0 : (data_a >> w_shamt);
      end
      c_OP_ARSH: begin
        w_load = 1'b1;
        w_err  = w_shbad;
        w_res  = w_shbad ? {WIDTH{data_a[WIDTH-1]}}
                         : WIDTH'($signed(data_a) >>> w_shamt);
      end
`ifdef ALU_MUL_EN
      c_OP_MUL: begin
        w_load = 1'b1;
        w_res  = w_prod[WIDTH-1:0];
        w_ovf  = !((&w_prod_hi) || !(|w_prod_hi));
      end
`endif
      default: begin
        // not an ALU operation: result holds, flag the error
        w_err = 1'b1;
      end
    endcase
  end

  // Registers are only written while enable is high, so anything on the
  // operand/opcode inputs during idle cycles never reaches the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end else if (enable) begin
      if (w_load) begin
        r_data <= w_res;
      end
      r_ovf <= w_ovf;
      r_err <= w_err;
    end
  end

  assign data_out = r_data;
  assign overflow = r_ovf;
  assign error    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pigro_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pigro_alu
// Description : Scoreboard testbench for pigro_alu. A driver issues directed
//               vectors on the falling edge and queues the hand-computed
//               response; a monitor pops and compares one entry just after
//               every rising edge at which a queued vector was applied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pigro_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [4:0]       opcode;
  logic             enable;
  logic [WIDTH-1:0] data_out;
  logic             overflow;
  logic             error;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             o;
    logic             e;
    string            nm;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_pass;

  pigro_alu #(.WIDTH(WIDTH), .SHW(5)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .data_a   (data_a),
    .data_b   (data_b),
    .opcode   (opcode),
    .enable   (enable),
    .data_out (data_out),
    .overflow (overflow),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one vector for the next rising edge and queue its expected result.
  task automatic issue(input logic r, input logic en, input logic [4:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] ed, input logic eo,
                       input logic ee, input string nm);
    exp_t x;
    @(negedge clk);
    rst    = r;
    enable = en;
    opcode = op;
    data_a = a;
    data_b = b;
    x.d  = ed;
    x.o  = eo;
    x.e  = ee;
    x.nm = nm;
    q.push_back(x);
  endtask

  // Monitor: one queued vector is consumed per rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_chk = n_chk + 1;
        if (data_out !== x.d || overflow !== x.o || error !== x.e) begin
          $display("FAIL %s: got data=%h ovf=%b err=%b, want data=%h ovf=%b err=%b",
                   x.nm, data_out, overflow, error, x.d, x.o, x.e);
        end else begin
          n_pass = n_pass + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    enable = 1'b0;
    opcode = 5'd0;
    data_a = '0;
    data_b = '0;

    // reset, then idle holds zero
    issue(1, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, "reset1");
    issue(1, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, "reset2");
    issue(0, 0, 5'd1, 32'h5, 32'h5, 32'h0, 0, 0, "idle1");
    issue(0, 0, 5'd1, 32'h7, 32'h9, 32'h0, 0, 0, "idle2");

    // add / sub incl. overflow boundaries
    issue(0, 1, 5'd1, 32'h5,        32'hFFFFFFF9, 32'hFFFFFFFE, 0, 0, "add_5_m7");
    issue(0, 1, 5'd1, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0, "add_ovf");
    issue(0, 1, 5'd2, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 0, "sub_ovf_min");
    issue(0, 1, 5'd2, 32'h0,        32'h80000000, 32'h80000000, 1, 0, "sub_0_min");
    issue(0, 1, 5'd2, 32'h10,       32'h3,        32'h0000000D, 0, 0, "sub_plain");

    // logic and shifts
    issue(0, 1, 5'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, "and");
    issue(0, 1, 5'd9, 32'h80000010, 32'h4,        32'hF8000001, 0, 0, "arsh_4");
    issue(0, 1, 5'd8, 32'h80000010, 32'h4,        32'h08000001, 0, 0, "rsh_4");
    issue(0, 1, 5'd7, 32'h1,        32'd31,       32'h80000000, 0, 0, "lsh_31");
    issue(0, 1, 5'd7, 32'h1,        32'd32,       32'h0,        0, 1, "lsh_32");
    issue(0, 1, 5'd8, 32'h12345678, 32'hFFFFFFFF, 32'h0,        0, 1, "rsh_neg");
    issue(0, 1, 5'd9, 32'h80000000, 32'd40,       32'hFFFFFFFF, 0, 1, "arsh_big");
    issue(0, 1, 5'd9, 32'h7FFFFFFF, 32'd0,        32'h7FFFFFFF, 0, 0, "arsh_0");

    // enable gating, illegal opcode, nop
    issue(0, 1, 5'd1,  32'h1, 32'h2, 32'h3, 0, 0, "add_1_2");
    issue(0, 0, 5'd2,  'x,    'x,    32'h3, 0, 0, "hold_x");
    issue(0, 1, 5'd12, 32'h1, 32'h1, 32'h3, 0, 1, "illegal_12");
    issue(0, 0, 5'd1,  32'h1, 32'h1, 32'h3, 0, 1, "hold_err");
    issue(0, 1, 5'd0,  32'h9, 32'h9, 32'h3, 0, 0, "nop");

    // overflow flag holds while idle, cleared by next enabled op
    issue(0, 1, 5'd1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0, "add_ovf2");
    issue(0, 0, 5'd3, 32'h0,        32'h0, 32'h80000000, 1, 0, "hold_ovf");
    issue(0, 1, 5'd0, 32'h0,        32'h0, 32'h80000000, 0, 0, "nop_clr_ovf");

    // back-to-back ops, then reset with enable high
    issue(0, 1, 5'd1, 32'd10,       32'd20,       32'd30,       0, 0, "b2b_add");
    issue(0, 1, 5'd5, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 0, 0, "b2b_xor");
    issue(0, 1, 5'd6, 32'h0,        32'h12345678, 32'hFFFFFFFF, 0, 0, "b2b_not");
    issue(0, 1, 5'd4, 32'h1,        32'h100,      32'h00000101, 0, 0, "b2b_or");
    issue(1, 1, 5'd1, 32'h7FFFFFFF, 32'h1,        32'h0,        0, 0, "rst_en");

    // opcode 10 and top of the illegal range
    issue(0, 1, 5'd1, 32'd4, 32'd5, 32'd9, 0, 0, "add_4_5");
`ifdef ALU_MUL_EN
    issue(0, 1, 5'd10, 32'hFFFFFFFD, 32'd7,     32'hFFFFFFEB, 0, 0, "mul_m3_7");
    issue(0, 1, 5'd10, 32'h00010000, 32'h10000, 32'h0,        1, 0, "mul_ovf");
    issue(0, 1, 5'd1,  32'd4,        32'd5,     32'd9,        0, 0, "add_4_5b");
`else
    issue(0, 1, 5'd10, 32'h3, 32'h7, 32'd9, 0, 1, "op10_illegal");
`endif
    issue(0, 1, 5'd31, 32'h3, 32'h7, 32'd9, 0, 1, "op31_illegal");
    issue(0, 0, 5'd0,  32'h0, 32'h0, 32'd9, 0, 1, "final_idle");

    // all queued vectors must have been consumed
    repeat (3) @(negedge clk);
    n_chk = n_chk + 1;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end else begin
      n_pass = n_pass + 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pigro_alu.md
Name: pigro_alu

Overview:
- 32-bit signed integer ALU for the PIGRO execution stage.
- Performs the arithmetic, logic and shift opcodes, i.e. those with opcode > NOP and opcode <= ARSH.
- Inputs come from the ex-stage operand registers. The result and two status flags (overflow, error) are registered on the clock edge, gated by an enable strobe.
- Load/store/compare/branch opcodes are handled outside this block; they must arrive with enable low.

Parameters:
- WIDTH, 32, operand/result width in bits (signed two's complement).
- SHW, 5, number of low bits of data_b used as shift amount (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_a  input  WIDTH  signed operand A.
- data_b  input  WIDTH  signed operand B (register value or immediate, selected upstream).
- opcode  input  5  operation code.
- enable  input  1  when 1, the operation is executed and outputs update on the next clk edge.
- data_out  output  WIDTH  signed result, registered.
- overflow  output  1  signed overflow flag, registered.
- error  output  1  illegal-operation flag, registered.

Behaviour:
- Opcode map (5-bit):
  - NOP=0.
  - ADD=1: a+b.
  - SUB=2: a-b.
  - AND=3, OR=4, XOR=5: bitwise.
  - NOT=6: ~a; b ignored.
  - LSH=7: a << b[4:0], zero fill.
  - RSH=8: logical right shift, zero fill.
  - ARSH=9: arithmetic right shift, sign fill.
  - Codes 10..31 are not ALU operations.
- Reset: on a clk edge with rst=1, data_out=0, overflow=0, error=0. rst overrides enable.
- Latency: 1 cycle. Inputs are sampled at a rising clk edge with enable=1; results are visible after that edge. No handshake; a new operation may be issued every cycle.
- enable=0: data_out, overflow and error all hold their previous values.
- enable=1 with a valid opcode 1..9: data_out=result, error=0.
- overflow:
  - ADD: set when both operands have the same sign and the result sign differs.
  - SUB: set when a and b have different signs and the result sign differs from a.
  - All other opcodes: overflow=0.
  - On overflow, data_out is the wrapped 32-bit result.
- Shifts:
  - The amount is b[4:0].
  - If b[31:5] is nonzero (negative or >31), error=1 and data_out is 0 for LSH/RSH.
  - For ARSH in that case, data_out is all sign bits of a and error=1.
  - Shift by 0 returns a unchanged.
- enable=1 with opcode NOP(0): data_out holds, overflow=0, error=0.
- enable=1 with opcode 10..31: data_out holds, overflow=0, error=1.
- Boundaries:
  - ADD 0x7FFFFFFF+1 gives 0x80000000 with overflow=1.
  - SUB 0x80000000-1 gives 0x7FFFFFFF with overflow=1.
  - SUB 0-0x80000000 gives 0x80000000 with overflow=1.
- Flags reflect only the most recent enabled operation.
- X on inputs while enable=0 must not propagate to the outputs.

Optional Feature:
- Macro ALU_MUL_EN.
- When defined:
  - Opcode 10 = MUL, a signed 32x32 multiply; data_out = low 32 bits of the product.
  - overflow=1 when the 64-bit product is not representable in 32 signed bits.
  - error=0; latency remains 1 cycle.
- When undefined: opcode 10 is illegal (error=1, data_out holds), like every other code from 10 to 31.

Test Plan:
- Reset with rst=1 for 2 cycles, then enable=0 -> data_out=0, overflow=0, error=0, and these hold while enable=0.
- ADD cases, then SUB, each with enable=1:
  - ADD a=5, b=-7 -> data_out=-2, ovf=0 next cycle.
  - ADD a=0x7FFFFFFF, b=1 -> 0x80000000, ovf=1.
  - SUB a=0x80000000, b=1 -> 0x7FFFFFFF, ovf=1.
- Logic/shift:
  - AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
  - ARSH a=0x80000010, b=4 -> 0xF8000001.
  - RSH same operands -> 0x08000001.
  - LSH a=1, b=31 -> 0x80000000.
  - LSH a=1, b=32 -> 0, error=1.
- Enable gating and illegal opcode:
  - ADD 1+2 with enable=1 -> 3.
  - Next cycle opcode=SUB with enable=0 -> stays 3.
  - Then opcode=12 with enable=1 -> data_out stays 3, error=1.
  - Then NOP -> error=0.
- Back-to-back ops plus mid-stream reset: issue ADD/XOR/NOT on consecutive cycles (NOT 0 -> 0xFFFFFFFF) and check each result one cycle later. Assert rst together with enable=1 -> outputs 0 on that edge.
- With ALU_MUL_EN:
  - MUL -3*7 -> -21, ovf=0.
  - MUL 0x10000*0x10000 -> 0, ovf=1.
- Without ALU_MUL_EN: opcode 10 -> error=1.
